// File: rtl/rx_packet_assembler.sv
// USB receive packet assembler: hunts for SYNC, checks the PID byte, then packs
// LSB-first data bytes into rx_fifo and reports completion, byte count and errors.
module rx_packet_assembler #(
    parameter int MAX_BYTES = 66
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_bit,
    input  logic       bit_strobe,
    input  logic       eop,
    input  logic       fifo_full,
    output logic       w_enable,
    output logic [7:0] w_data,
    output logic [3:0] rx_pid,
    output logic       pid_valid,
    output logic [6:0] byte_count,
    output logic       packet_done,
    output logic       rx_error
);

    typedef enum logic [1:0] {
        IDLE,
        PID,
        DATA,
        ERR
    } state_t;

    localparam logic [6:0] MAX_CNT   = 7'(MAX_BYTES);
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] SHIFT_RST = 8'hFF;

    state_t     state, state_n;
    logic [7:0] shift_q, shift_n;
    logic [7:0] shifted;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       bit_ok;

    logic       w_enable_n;
    logic [7:0] w_data_n;
    logic [3:0] rx_pid_n;
    logic       pid_valid_n;
    logic [6:0] byte_count_n;
    logic       packet_done_n;
    logic       rx_error_n;

    // Upper nibble of a PID byte must be the ones' complement of the lower nibble.
    function automatic logic pid_check(input logic [7:0] b);
        return (b[7:4] == ~b[3:0]);
    endfunction

    // eop has priority: a bit strobed in the same cycle is discarded.
    assign bit_ok  = bit_strobe & ~eop;
    assign shifted = {d_bit, shift_q[7:1]};

    always_comb begin
        state_n       = state;
        shift_n       = shift_q;
        bit_cnt_n     = bit_cnt;
        w_enable_n    = 1'b0;
        w_data_n      = w_data;
        rx_pid_n      = rx_pid;
        pid_valid_n   = pid_valid;
        byte_count_n  = byte_count;
        packet_done_n = 1'b0;
        rx_error_n    = rx_error;

        if (bit_ok) begin
            shift_n = shifted;
        end

        case (state)
            IDLE: begin
                if (bit_ok && (shifted == SYNC_BYTE)) begin
                    state_n      = PID;
                    bit_cnt_n    = 3'd0;
                    rx_error_n   = 1'b0;
                    pid_valid_n  = 1'b0;
                    byte_count_n = 7'd0;
                end
            end

            PID: begin
                if (eop) begin
                    rx_error_n    = 1'b1;
                    packet_done_n = 1'b1;
                    state_n       = IDLE;
                    shift_n       = SHIFT_RST;
                end else if (bit_ok) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (pid_check(shifted)) begin
                            rx_pid_n    = shifted[3:0];
                            pid_valid_n = 1'b1;
                            state_n     = DATA;
                        end else begin
                            rx_error_n = 1'b1;
                            state_n    = ERR;
                        end
                    end
                end
            end

            DATA: begin
                if (eop) begin
                    // A non-zero bit counter means a partial byte, which is dropped.
                    if (bit_cnt != 3'd0) begin
                        rx_error_n = 1'b1;
                    end
                    packet_done_n = 1'b1;
                    state_n       = IDLE;
                    shift_n       = SHIFT_RST;
                end else if (bit_ok) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (fifo_full || (byte_count >= MAX_CNT)) begin
                            rx_error_n = 1'b1;
                            state_n    = ERR;
                        end else begin
                            w_enable_n   = 1'b1;
                            w_data_n     = shifted;
                            byte_count_n = byte_count + 7'd1;
                        end
                    end
                end
            end

            ERR: begin
                if (eop) begin
                    packet_done_n = 1'b1;
                    state_n       = IDLE;
                    shift_n       = SHIFT_RST;
                end
            end

            default: begin
                state_n = IDLE;
                shift_n = SHIFT_RST;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            shift_q     <= SHIFT_RST;
            bit_cnt     <= 3'd0;
            w_enable    <= 1'b0;
            w_data      <= 8'h00;
            rx_pid      <= 4'h0;
            pid_valid   <= 1'b0;
            byte_count  <= 7'd0;
            packet_done <= 1'b0;
            rx_error    <= 1'b0;
        end else begin
            state       <= state_n;
            shift_q     <= shift_n;
            bit_cnt     <= bit_cnt_n;
            w_enable    <= w_enable_n;
            w_data      <= w_data_n;
            rx_pid      <= rx_pid_n;
            pid_valid   <= pid_valid_n;
            byte_count  <= byte_count_n;
            packet_done <= packet_done_n;
            rx_error    <= rx_error_n;
        end
    end

endmodule

// File: tb/tb_rx_packet_assembler.sv
// Directed and randomized packet stimulus for rx_packet_assembler, checked against
// a packet-level reference model of the expected writes and status outputs.
module tb_rx_packet_assembler;

    localparam int MAX_BYTES = 66;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       d_bit;
    logic       bit_strobe;
    logic       eop;
    logic       fifo_full;
    logic       w_enable;
    logic [7:0] w_data;
    logic [3:0] rx_pid;
    logic       pid_valid;
    logic [6:0] byte_count;
    logic       packet_done;
    logic       rx_error;

    rx_packet_assembler #(.MAX_BYTES(MAX_BYTES)) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .d_bit      (d_bit),
        .bit_strobe (bit_strobe),
        .eop        (eop),
        .fifo_full  (fifo_full),
        .w_enable   (w_enable),
        .w_data     (w_data),
        .rx_pid     (rx_pid),
        .pid_valid  (pid_valid),
        .byte_count (byte_count),
        .packet_done(packet_done),
        .rx_error   (rx_error)
    );

    always #5 tb_clk = ~tb_clk;

    int errors = 0;
    int checks = 0;

    // Monitor: every cycle with w_enable high is one FIFO write.
    logic [7:0] wr_log[$];
    int         pd_total = 0;

    always @(negedge tb_clk) begin
        if (w_enable) wr_log.push_back(w_data);
        if (packet_done) pd_total++;
    end

    // Reference model state, as seen from outside the block.
    logic [7:0] pkt_data[$];
    logic [7:0] exp_q[$];
    logic [3:0] m_pid   = 4'h0;
    logic       m_pvld  = 1'b0;
    logic [6:0] m_cnt   = 7'd0;
    logic       m_err   = 1'b0;
    logic [7:0] m_wdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge tb_clk);
        d_bit      = b;
        bit_strobe = 1'b1;
        @(negedge tb_clk);
        bit_strobe = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic send_eop(input bit with_bit);
        @(negedge tb_clk);
        eop        = 1'b1;
        bit_strobe = with_bit;
        d_bit      = 1'b1;
        @(negedge tb_clk);
        eop        = 1'b0;
        bit_strobe = 1'b0;
        repeat (3) @(negedge tb_clk);
    endtask

    task automatic check_outputs(input string name, input int wr_base, input int pd_base, input int exp_pd);
        check({name, " writes"}, wr_log.size() - wr_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && (wr_base + i) < wr_log.size(); i++)
            check({name, " w_data"}, wr_log[wr_base + i], exp_q[i]);
        check({name, " byte_count"}, byte_count, m_cnt);
        check({name, " rx_pid"}, rx_pid, m_pid);
        check({name, " pid_valid"}, pid_valid, m_pvld);
        check({name, " rx_error"}, rx_error, m_err);
        check({name, " packet_done"}, pd_total - pd_base, exp_pd);
        check({name, " w_data_hold"}, w_data, m_wdata);
        check({name, " w_enable_idle"}, w_enable, 1'b0);
    endtask

    // Drives SYNC, pid_bits bits of the PID, pkt_data (fifo_full held high during
    // byte full_at), extra trailing bits and an eop, then predicts the outcome.
    task automatic run_packet(input logic [7:0] pid, input int pid_bits, input int full_at,
                              input int extra, input bit eop_bit, input string name);
        int wr_base;
        int pd_base;
        wr_base = wr_log.size();
        pd_base = pd_total;

        send_byte(8'h80);
        for (int i = 0; i < pid_bits; i++) send_bit(pid[i]);
        if (pid_bits == 8) begin
            for (int i = 0; i < pkt_data.size(); i++) begin
                fifo_full = (i == full_at);
                send_byte(pkt_data[i]);
            end
            fifo_full = 1'b0;
            for (int i = 0; i < extra; i++) send_bit(1'($urandom_range(0, 1)));
        end
        send_eop(eop_bit);

        exp_q.delete();
        m_err  = 1'b0;
        m_pvld = 1'b0;
        m_cnt  = 7'd0;
        if (pid_bits < 8 || pid[7:4] != ~pid[3:0]) begin
            m_err = 1'b1;
        end else begin
            m_pid  = pid[3:0];
            m_pvld = 1'b1;
            for (int i = 0; i < pkt_data.size(); i++) begin
                if (i == full_at || i >= MAX_BYTES) begin
                    m_err = 1'b1;
                    break;
                end
                exp_q.push_back(pkt_data[i]);
                m_cnt++;
                m_wdata = pkt_data[i];
            end
            if (!m_err && extra != 0) m_err = 1'b1;
        end
        check_outputs(name, wr_base, pd_base, 1);
    endtask

    task automatic fill_random(input int n);
        pkt_data.delete();
        for (int i = 0; i < n; i++) pkt_data.push_back(8'($urandom));
    endtask

    task automatic check_reset_values(input string name);
        check({name, " w_enable"}, w_enable, 1'b0);
        check({name, " w_data"}, w_data, 8'h00);
        check({name, " rx_pid"}, rx_pid, 4'h0);
        check({name, " pid_valid"}, pid_valid, 1'b0);
        check({name, " byte_count"}, byte_count, 7'd0);
        check({name, " packet_done"}, packet_done, 1'b0);
        check({name, " rx_error"}, rx_error, 1'b0);
    endtask

    initial begin
        int         pd_base;
        int         wr_base;
        int         n;
        int         fa;
        int         ex;
        int         pb;
        logic [7:0] pid;
        logic [3:0] nib;
        logic [7:0] c0_bits;

        n_rst      = 1'b0;
        d_bit      = 1'b0;
        bit_strobe = 1'b0;
        eop        = 1'b0;
        fifo_full  = 1'b0;
        repeat (3) @(negedge tb_clk);
        check_reset_values("reset");
        n_rst = 1'b1;
        @(negedge tb_clk);

        pkt_data = '{8'hA5, 8'h3C};
        run_packet(8'hC3, 8, -1, 0, 1'b0, "basic");

        pkt_data = '{8'h12, 8'h34};
        run_packet(8'hC4, 8, -1, 0, 1'b0, "bad_pid");

        pkt_data = '{8'h11, 8'h22};
        run_packet(8'h4B, 8, 0, 0, 1'b0, "fifo_full");

        pkt_data = '{8'h99};
        run_packet(8'hD2, 8, -1, 0, 1'b0, "recover");

        pkt_data = '{8'h55};
        run_packet(8'hC3, 8, -1, 3, 1'b0, "partial");

        pkt_data.delete();
        run_packet(8'hC3, 5, -1, 0, 1'b0, "short_pid");

        pkt_data = '{8'h5A};
        run_packet(8'hE1, 8, -1, 0, 1'b1, "eop_with_bit");

        // 0,0,0,0,0,0,1,1 leaves 8'hC0 in the window: not a SYNC; eop in IDLE is ignored.
        pd_base = pd_total;
        wr_base = wr_log.size();
        c0_bits = 8'hC0;
        for (int i = 0; i < 8; i++) send_bit(c0_bits[i]);
        send_eop(1'b0);
        check("near_sync packet_done", pd_total - pd_base, 0);
        check("near_sync writes", wr_log.size() - wr_base, 0);
        check("near_sync pid_valid", pid_valid, m_pvld);
        check("near_sync rx_error", rx_error, m_err);
        check("near_sync byte_count", byte_count, m_cnt);

        pkt_data = '{8'hA5, 8'h0F, 8'hF0};
        run_packet(8'h69, 8, -1, 0, 1'b0, "after_near_sync");

        fill_random(MAX_BYTES + 1);
        run_packet(8'hC3, 8, -1, 0, 1'b0, "overflow");

        fill_random(MAX_BYTES);
        run_packet(8'h2D, 8, -1, 0, 1'b0, "max_bytes");

        for (int p = 0; p < 25; p++) begin
            n   = $urandom_range(0, 6);
            nib = 4'($urandom);
            pid = ($urandom_range(0, 3) != 0) ? {~nib, nib} : 8'($urandom);
            fa  = (n > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            ex  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            pb  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : 8;
            fill_random(n);
            run_packet(pid, pb, fa, ex, 1'($urandom_range(0, 1)), "random");
        end

        // Asynchronous reset in the middle of DATA after two writes.
        wr_base = wr_log.size();
        send_byte(8'h80);
        send_byte(8'hC3);
        send_byte(8'h01);
        send_byte(8'h02);
        send_bit(1'b1);
        repeat (2) @(negedge tb_clk);
        check("pre_reset writes", wr_log.size() - wr_base, 2);
        check("pre_reset byte_count", byte_count, 7'd2);
        #2 n_rst = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge tb_clk);
        n_rst   = 1'b1;
        m_pid   = 4'h0;
        m_wdata = 8'h00;
        m_pvld  = 1'b0;
        m_cnt   = 7'd0;
        m_err   = 1'b0;
        @(negedge tb_clk);

        pkt_data = '{8'hFF};
        run_packet(8'hC3, 8, -1, 0, 1'b0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
